id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, ports first: clk (in, 1, rising-edge clock), rst_n (in, 1, async active-low reset).
REQ-002 SHALL have decode inputs: id_valid 1; id_rs_data/id_rt_data 32 (register-file reads); id_rs/id_rt/id_rd 5; id_imm 32 (sign-extended); id_shmt 5; id_alu_op 4; id_alu_src 1 (1 = in2 from imm); id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg 1 each.
REQ-003 SHALL have forwarding inputs: mem_reg_write 1, mem_rd 5, mem_result 32 (EX/MEM stage); wb_reg_write 1, wb_rd 5, wb_result 32 (MEM/WB stage).
REQ-004 SHALL have control inputs: flush 1 (squash instruction in ID), hold 1 (downstream busy).
REQ-005 SHALL have outputs: stall_id 1 (freeze PC and IF/ID); ex_valid 1; ex_in1/ex_in2 32 and ex_alu_op 4, ex_shmt 5 (ALU operands); ex_store_data 32; ex_rd 5; ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg 1 each.

Function
REQ-006 SHALL register all id_* fields into the ID/EX register on each rising clk edge when loading; latency ID to EX one cycle.
REQ-007 Per-edge priority SHALL be: flush, then hold, then hazard bubble, then normal load.
REQ-008 flush SHALL load a bubble: ex_valid=0 and all ex_* control bits 0; hold is ignored that edge.
REQ-009 hold (no flush) SHALL keep the ID/EX register unchanged and drive stall_id=1.
REQ-010 Load-use hazard: EX entry valid and mem_read and ex_rd!=0 and (ex_rd==id_rs, or ex_rd==id_rt with id_alu_src==0 or id_mem_write==1), with id_valid=1.
REQ-011 On load-use hazard (no flush/hold), SHALL drive stall_id=1 combinationally and load a bubble; the ID instruction is reloaded next cycle.
REQ-012 When ex_valid=0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg SHALL read 0.
REQ-013 Forwarding (combinational, from registered rs/rt): MEM match (mem_reg_write, mem_rd!=0, mem_rd==reg) selects mem_result; else WB match selects wb_result; else registered data.
REQ-014 Register 0 SHALL never be forwarded or hazard-detected.
REQ-015 ex_in1 = forwarded rs; ex_in2 = registered imm if alu_src else forwarded rt; ex_store_data = forwarded rt always.
REQ-016 id_valid=0 SHALL load a bubble and raise no hazard.

Reset
REQ-017 rst_n low SHALL immediately clear every ID/EX register to 0; ex_* outputs and stall_id read 0 during and after reset until the first load.
REQ-018 Reset asserted mid-stall SHALL drop stall_id to 0 and discard the held entry.

Configuration
REQ-019 Macro ID_EX_FORWARDING_EN defined: REQ-013 forwarding built as stated.
REQ-020 Macro undefined: no forwarding mux; ex_in1/ex_in2/ex_store_data use registered data only; stall/bubble (as REQ-011) also on any RAW match against the EX entry (any reg_write) or mem_rd/mem_reg_write; WB hazards resolved by register-file write-before-read; mem_result/wb_result unused.

Structure
REQ-021 Shared package mips_pkg SHALL hold ALU op codes (AND 0000, OR 0001, ADD 0010, SLL 0011, SUB 0110, SLT 0111, NOR 1100), data width 32, register-index width 5.
REQ-022 Forwarding select and hazard compare SHALL live in sub-module fwd_unit, instantiated once; the pipeline register stays in id_ex_stage.

Verification
REQ-023 Normal load: id_rs_data=5, id_imm=7, alu_src=1, alu_op=0010 -> next cycle ex_in1=5, ex_in2=7, ex_alu_op=0010, ex_valid=1.
REQ-024 MEM priority: ex rs=3, mem_rd=3 mem_result=0xAA, wb_rd=3 wb_result=0xBB, both write -> ex_in1=0xAA; with mem_reg_write=0 -> 0xBB; with rs=0 -> registered data.
REQ-025 Load-use: lw to r4 in EX, ID add uses rs=4 -> stall_id=1 one cycle, ex_valid=0 next edge, add loaded the following edge.
REQ-026 flush and hold both 1 -> next edge ex_valid=0, control bits 0; hold alone 3 cycles -> ex_* unchanged, stall_id=1 throughout.
REQ-027 rst_n low during hold with valid entry -> ex_valid=0, ex_in1=0, stall_id=0 immediately, no clock edge needed.
REQ-028 Without ID_EX_FORWARDING_EN: add writes r2 in EX, next uses r2 -> stall_id=1 two cycles (EX then MEM), then load.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: datapath widths, ALU op codes, the ID/EX entry
// layout and a register-match helper used by forwarding and hazard logic.
package mips_pkg;
   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int OP_W   = 4;
   localparam int SHMT_W = 5;

   typedef enum logic [OP_W-1:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SLL = 4'b0011,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_NOR = 4'b1100
   } alu_op_e;

   typedef struct packed {
      logic              valid;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
      logic [SHMT_W-1:0] shmt;
      logic [OP_W-1:0]   alu_op;
      logic              alu_src;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              mem_to_reg;
   } id_ex_t;

   // Register 0 is hard-wired, so a write to it never matches a reader.
   function automatic logic reg_match(input logic             wr_en,
                                      input logic [REG_W-1:0] wr_rd,
                                      input logic [REG_W-1:0] rd);
      return wr_en && (wr_rd != '0) && (wr_rd == rd);
   endfunction
endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select and ID-stage hazard compare for the ID/EX stage.
// Forwarding paths exist only when ID_EX_FORWARDING_EN is defined; otherwise RAW hazards stall.
module fwd_unit
   import mips_pkg::*;
(
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic              ex_reg_write,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic [REG_W-1:0]  ex_rs,
   input  logic [REG_W-1:0]  ex_rt,
   input  logic [DATA_W-1:0] ex_rs_data,
   input  logic [DATA_W-1:0] ex_rt_data,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic              id_alu_src,
   input  logic              id_mem_write,
   input  logic              mem_reg_write,
   input  logic [REG_W-1:0]  mem_rd,
   input  logic [DATA_W-1:0] mem_result,
   input  logic              wb_reg_write,
   input  logic [REG_W-1:0]  wb_rd,
   input  logic [DATA_W-1:0] wb_result,
   output logic [DATA_W-1:0] fwd_rs_data,
   output logic [DATA_W-1:0] fwd_rt_data,
   output logic              hazard
);
   // rt is only a source when it feeds the ALU or supplies store data.
   logic id_uses_rt;
   logic ex_hits_id;

   assign id_uses_rt = !id_alu_src || id_mem_write;
   assign ex_hits_id = (ex_rd != '0) &&
                       ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

`ifdef ID_EX_FORWARDING_EN
   logic unused_fwd;

   assign hazard     = id_valid && ex_valid && ex_mem_read && ex_hits_id;
   assign unused_fwd = ex_reg_write;

   always_comb begin
      fwd_rs_data = ex_rs_data;
      if (reg_match(mem_reg_write, mem_rd, ex_rs))
         fwd_rs_data = mem_result;
      else if (reg_match(wb_reg_write, wb_rd, ex_rs))
         fwd_rs_data = wb_result;
   end

   always_comb begin
      fwd_rt_data = ex_rt_data;
      if (reg_match(mem_reg_write, mem_rd, ex_rt))
         fwd_rt_data = mem_result;
      else if (reg_match(wb_reg_write, wb_rd, ex_rt))
         fwd_rt_data = wb_result;
   end
`else
   logic mem_hits_id;
   logic unused_fwd;

   // WB-stage producers are covered by the register file's write-before-read.
   assign mem_hits_id = reg_match(mem_reg_write, mem_rd, id_rs) ||
                        (id_uses_rt && reg_match(mem_reg_write, mem_rd, id_rt));
   assign hazard      = id_valid &&
                        ((ex_valid && (ex_mem_read || ex_reg_write) && ex_hits_id) ||
                         mem_hits_id);
   assign fwd_rs_data = ex_rs_data;
   assign fwd_rt_data = ex_rt_data;
   assign unused_fwd  = ^{ex_rs, ex_rt, mem_result, wb_reg_write, wb_rd, wb_result};
`endif
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/hold/load-use bubble control and operand muxing.
// Build option: define ID_EX_FORWARDING_EN to enable MEM/WB operand forwarding.
module id_ex_stage
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [SHMT_W-1:0] id_shmt,
   input  logic [OP_W-1:0]   id_alu_op,
   input  logic              id_alu_src,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_mem_to_reg,
   input  logic              mem_reg_write,
   input  logic [REG_W-1:0]  mem_rd,
   input  logic [DATA_W-1:0] mem_result,
   input  logic              wb_reg_write,
   input  logic [REG_W-1:0]  wb_rd,
   input  logic [DATA_W-1:0] wb_result,
   input  logic              flush,
   input  logic              hold,
   output logic              stall_id,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_in1,
   output logic [DATA_W-1:0] ex_in2,
   output logic [OP_W-1:0]   ex_alu_op,
   output logic [SHMT_W-1:0] ex_shmt,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [REG_W-1:0]  ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg
);
   id_ex_t            ex_reg;
   id_ex_t            ex_next;
   logic              hazard;
   logic [DATA_W-1:0] fwd_rs_data;
   logic [DATA_W-1:0] fwd_rt_data;

   fwd_unit u_fwd (
      .ex_valid     (ex_reg.valid),
      .ex_mem_read  (ex_reg.mem_read),
      .ex_reg_write (ex_reg.reg_write),
      .ex_rd        (ex_reg.rd),
      .ex_rs        (ex_reg.rs),
      .ex_rt        (ex_reg.rt),
      .ex_rs_data   (ex_reg.rs_data),
      .ex_rt_data   (ex_reg.rt_data),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_alu_src   (id_alu_src),
      .id_mem_write (id_mem_write),
      .mem_reg_write(mem_reg_write),
      .mem_rd       (mem_rd),
      .mem_result   (mem_result),
      .wb_reg_write (wb_reg_write),
      .wb_rd        (wb_rd),
      .wb_result    (wb_result),
      .fwd_rs_data  (fwd_rs_data),
      .fwd_rt_data  (fwd_rt_data),
      .hazard       (hazard)
   );

   // Bubbles clear the whole entry so squashed data never reaches EX.
   always_comb begin
      ex_next = ex_reg;
      if (flush) begin
         ex_next = '0;
      end else if (hold) begin
         ex_next = ex_reg;
      end else if (hazard || !id_valid) begin
         ex_next = '0;
      end else begin
         ex_next.valid      = 1'b1;
         ex_next.rs         = id_rs;
         ex_next.rt         = id_rt;
         ex_next.rd         = id_rd;
         ex_next.rs_data    = id_rs_data;
         ex_next.rt_data    = id_rt_data;
         ex_next.imm        = id_imm;
         ex_next.shmt       = id_shmt;
         ex_next.alu_op     = id_alu_op;
         ex_next.alu_src    = id_alu_src;
         ex_next.reg_write  = id_reg_write;
         ex_next.mem_read   = id_mem_read;
         ex_next.mem_write  = id_mem_write;
         ex_next.mem_to_reg = id_mem_to_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ex_reg <= '0;
      else
         ex_reg <= ex_next;
   end

   // Gated by rst_n so a reset during a hold releases the front end at once.
   assign stall_id      = rst_n && !flush && (hold || hazard);

   assign ex_valid      = ex_reg.valid;
   assign ex_in1        = fwd_rs_data;
   assign ex_in2        = ex_reg.alu_src ? ex_reg.imm : fwd_rt_data;
   assign ex_store_data = fwd_rt_data;
   assign ex_alu_op     = ex_reg.alu_op;
   assign ex_shmt       = ex_reg.shmt;
   assign ex_rd         = ex_reg.rd;
   assign ex_reg_write  = ex_reg.valid && ex_reg.reg_write;
   assign ex_mem_read   = ex_reg.valid && ex_reg.mem_read;
   assign ex_mem_write  = ex_reg.valid && ex_reg.mem_write;
   assign ex_mem_to_reg = ex_reg.valid && ex_reg.mem_to_reg;
endmodule
